bisqrt_stream_sched: RTL and testbench

Round-robin scheduler that shares one unipolar stochastic square-root unit (BISQRT kernel) among `NREQ` binary requesters. For each granted job it:
- clears the unit;
- generates the unary input stream from the binary operand and an external random number;
- discards a warm-up window;
- counts output ones over 2^`WIDTH` cycles;
- returns the count as a binary result over a valid/ready response channel.

It sits between the binary-domain clients and the single sqrt datapath instance.

---
 rtl/bisqrt_stream_sched.sv | 162 ++++++++++++++++
 tb/tb_bisqrt_stream_sched.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bisqrt_stream_sched.sv
// Round-robin scheduler that time-shares one stochastic square-root kernel among
// NREQ binary clients: clear, warm up, count 2^WIDTH output bits, return the count.
module bisqrt_stream_sched #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int WARMUP = 4,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH:0]          rsp_data,
  input  logic [WIDTH-1:0]        rng,
  output logic                    rng_en,
  output logic                    sqrt_clr_n,
  output logic                    sqrt_in,
  input  logic                    sqrt_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_WARM  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [WIDTH:0] WARM_LAST = (WIDTH+1)'((WARMUP > 0) ? WARMUP - 1 : 0);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   ones_q, ones_d;
  logic             clr_n_q;

  logic             grant_vld_s;
  logic [IDW-1:0]   grant_idx_s;
  logic             can_grant_s;

  // Round-robin search: first requester above the last grant, wrapping.
  always_comb begin
    int cand;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand        = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + 1 + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end else begin
        cand = cand;
      end
      if (!grant_vld_s && req_valid[cand]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = IDW'(cand);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Grants wait until the kernel has left reset once (clr_n_q high).
  assign can_grant_s = (state_q == S_IDLE) && clr_n_q && grant_vld_s;

  always_comb begin
    req_ready = '0;
    if (can_grant_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    case (state_q)
      S_IDLE: begin
        if (can_grant_s) begin
          state_d = S_CLEAR;
          ptr_d   = grant_idx_s;
          id_d    = grant_idx_s;
          op_d    = req_data[int'(grant_idx_s)*WIDTH +: WIDTH];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        ones_d  = '0;
        state_d = (WARMUP == 0) ? S_RUN : S_WARM;
      end
      S_WARM: begin
        if (cnt_q == WARM_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d   = cnt_q + {{WIDTH{1'b0}}, 1'b1};
        end
      end
      S_RUN: begin
        // The MSB of the cycle counter sets after exactly 2^WIDTH RUN cycles.
        ones_d = ones_q + {{WIDTH{1'b0}}, sqrt_out};
        cnt_d  = cnt_q + {{WIDTH{1'b0}}, 1'b1};
        if (cnt_d[WIDTH]) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
      clr_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      clr_n_q <= (state_d != S_CLEAR);
    end
  end

  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_id     = id_q;
  assign rsp_data   = ones_q;
  assign rng_en     = (state_q == S_WARM) || (state_q == S_RUN);
  assign sqrt_in    = rng_en && (rng < op_q);
  assign sqrt_clr_n = clr_n_q;

endmodule

// File: tb/tb_bisqrt_stream_sched.sv
// Scoreboard bench for bisqrt_stream_sched: a WIDTH=4 instance for control behaviour
// and a WIDTH=8 instance driving a behavioural square-root kernel with a Sobol source.
module tb_bisqrt_stream_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_data;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_data;
  logic [3:0]  rng;
  logic        rng_en, sqrt_clr_n, sqrt_in, sqrt_out;
  int          mode;

  logic [3:0]  req_valid8, req_ready8;
  logic [31:0] req_data8;
  logic        rsp_valid8, rsp_ready8;
  logic [1:0]  rsp_id8;
  logic [8:0]  rsp_data8;
  logic [7:0]  rng8;
  logic        rng_en8, clr8, sin8, sout8;

  typedef struct {int id; int data;} exp_t;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bisqrt_stream_sched #(.NREQ(4), .WIDTH(4), .WARMUP(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rng(rng), .rng_en(rng_en),
    .sqrt_clr_n(sqrt_clr_n), .sqrt_in(sqrt_in), .sqrt_out(sqrt_out));

  bisqrt_stream_sched #(.NREQ(4), .WIDTH(8), .WARMUP(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid8), .req_data(req_data8),
    .req_ready(req_ready8), .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready8),
    .rsp_id(rsp_id8), .rsp_data(rsp_data8), .rng(rng8), .rng_en(rng_en8),
    .sqrt_clr_n(clr8), .sqrt_in(sin8), .sqrt_out(sout8));

  // mode 0: kernel output tied 0, 1: tied 1, 2: loop the input stream back
  assign sqrt_out = (mode == 2) ? sqrt_in : (mode == 1);

  logic [3:0] rng_q = 4'd0;
  always @(posedge clk) if (rng_en) rng_q <= rng_q + 4'd1;
  assign rng = rng_q;

  // Per-job stream statistics, restarted at every grant.
  int en_cnt = 0;
  int run_ones = 0;
  always @(negedge clk) begin
    #1;
    if (req_ready != 4'd0) begin
      en_cnt   <= 0;
      run_ones <= 0;
    end else if (rng_en) begin
      if (en_cnt >= 2) run_ones <= run_ones + int'(sin_bit());
      en_cnt <= en_cnt + 1;
    end
  end
  function automatic logic sin_bit();
    return sqrt_in;
  endfunction

  logic [7:0] sob_q = 8'd0;
  always @(posedge clk) if (rng_en8) sob_q <= sob_q + 8'd1;
  assign rng8 = {<<{sob_q}};

  // Behavioural sqrt kernel: emits a one whenever (ones+1)^2 <= inputs_seen*cycles.
  int   k_n, k_in, k_y;
  logic k_out;
  always @(posedge clk or negedge clr8) begin
    int nn, ni;
    logic emit;
    if (!clr8) begin
      k_n <= 0; k_in <= 0; k_y <= 0; k_out <= 1'b0;
    end else begin
      nn   = k_n + 1;
      ni   = k_in + int'(sin8);
      emit = ((k_y + 1) * (k_y + 1) <= ni * nn);
      k_n   <= nn;
      k_in  <= ni;
      k_y   <= k_y + int'(emit);
      k_out <= emit;
    end
  end
  assign sout8 = k_out;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_grant(output int g, output int cyc);
    g = -1; cyc = 0;
    #1;
    while (req_ready == 4'd0 && cyc < 200) begin
      @(negedge clk); #1; cyc++;
    end
    for (int k = 0; k < 4; k++) if (req_ready[k]) g = k;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    #1;
    while (!rsp_valid && cyc < 400) begin
      @(negedge clk); #1; cyc++;
    end
    if (!rsp_valid) cyc = -1;
  endtask

  task automatic test_reset();
    int c;
    exp_t e;
    rst_n = 1'b0; req_valid = 4'hF; req_data = 16'h0000; rsp_ready = 1'b1; mode = 1;
    req_valid8 = 4'h0; req_data8 = 32'h0; rsp_ready8 = 1'b1;
    repeat (3) tick();
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, rng_en, sqrt_in, sqrt_clr_n} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {req_ready, rsp_valid, rsp_id, rsp_data, rng_en, sqrt_in, sqrt_clr_n});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'd0) begin errors++; $display("FAIL reset_release_ready: got %b expected 0000", req_ready); end
    tick(); #1;
    checks++;
    if (sqrt_clr_n !== 1'b1) begin errors++; $display("FAIL reset_clr_rise: got %b expected 1", sqrt_clr_n); end
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready); end
    exp_q.push_back('{0, 16});
    tick(); req_valid = 4'h0;
    wait_rsp(c);
    e = exp_q.pop_front();
    checks++;
    if (rsp_id !== 2'(e.id) || rsp_data !== 5'(e.data)) begin
      errors++; $display("FAIL reset_job_rsp: got id %0d data %0d expected id %0d data %0d", rsp_id, rsp_data, e.id, e.data);
    end
    tick();
  endtask

  task automatic test_latency();
    int g, c;
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      mode = (pass == 0) ? 1 : 0;
      req_data = 16'h0900; req_valid = 4'b0100;
      wait_grant(g, c);
      checks++;
      if (g !== 2) begin errors++; $display("FAIL lat_grant: got %0d expected 2", g); end
      exp_q.push_back('{2, (pass == 0) ? 16 : 0});
      tick(); req_valid = 4'h0;
      wait_rsp(c);
      checks++;
      if (c + 1 !== 20) begin errors++; $display("FAIL lat_cycles: got %0d expected 20", c + 1); end
      e = exp_q.pop_front();
      checks++;
      if (rsp_id !== 2'(e.id) || rsp_data !== 5'(e.data)) begin
        errors++; $display("FAIL lat_rsp: got id %0d data %0d expected id %0d data %0d", rsp_id, rsp_data, e.id, e.data);
      end
      tick();
    end
  endtask

  task automatic test_stream();
    int g, c;
    exp_t e;
    logic [3:0] ops [2];
    ops[0] = 4'd9; ops[1] = 4'd0;
    mode = 2;
    for (int i = 0; i < 2; i++) begin
      req_data = {8'h00, ops[i], 4'h0}; req_valid = 4'b0010;
      wait_grant(g, c);
      exp_q.push_back('{1, int'(ops[i])});
      tick(); req_valid = 4'h0;
      wait_rsp(c);
      e = exp_q.pop_front();
      checks++;
      if (rsp_id !== 2'(e.id) || rsp_data !== 5'(e.data)) begin
        errors++; $display("FAIL stream_rsp: got id %0d data %0d expected id %0d data %0d", rsp_id, rsp_data, e.id, e.data);
      end
      checks++;
      if (run_ones !== int'(ops[i])) begin errors++; $display("FAIL stream_run_ones: got %0d expected %0d", run_ones, ops[i]); end
      checks++;
      if (en_cnt !== 18) begin errors++; $display("FAIL stream_rng_en: got %0d expected 18", en_cnt); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int g, c;
    exp_t e;
    mode = 1; rsp_ready = 1'b0;
    req_data = 16'h5A5A; req_valid = 4'b1000;
    wait_grant(g, c);
    checks++;
    if (g !== 3) begin errors++; $display("FAIL bp_grant: got %0d expected 3", g); end
    exp_q.push_back('{3, 16});
    tick(); req_valid = 4'b0011;
    wait_rsp(c);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, req_ready, rsp_id, rsp_data} !== {1'b1, 4'd0, 2'(e.id), 5'(e.data)}) begin
        errors++; $display("FAIL bp_hold: cycle %0d got v%b r%b id %0d data %0d expected v1 r0000 id %0d data %0d",
                           i, rsp_valid, req_ready, rsp_id, rsp_data, e.id, e.data);
      end
      tick(); #1;
    end
    tick(); rsp_ready = 1'b1;
    wait_grant(g, c);
    checks++;
    if (g !== 0 || c !== 1) begin errors++; $display("FAIL bp_regrant: got grant %0d after %0d expected grant 0 after 1", g, c); end
    exp_q.push_back('{0, 16});
    tick(); req_valid = 4'h0;
    wait_rsp(c);
    e = exp_q.pop_front();
    checks++;
    if (rsp_id !== 2'(e.id) || rsp_data !== 5'(e.data)) begin
      errors++; $display("FAIL bp_rsp2: got id %0d data %0d expected id %0d data %0d", rsp_id, rsp_data, e.id, e.data);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int g, c;
    exp_t e;
    int gr_exp [11];
    gr_exp = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 0};
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    mode = 1; req_valid = 4'hF;
    for (int i = 0; i < 11; i++) begin
      wait_grant(g, c);
      checks++;
      if (g !== gr_exp[i]) begin errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", i, g, gr_exp[i]); end
      if (i > 0) begin
        checks++;
        if (c !== 1) begin errors++; $display("FAIL rr_gap%0d: got %0d expected 1", i, c); end
      end
      exp_q.push_back('{g, 16});
      tick();
      if (i == 7) req_valid = 4'b0101;
      wait_rsp(c);
      e = exp_q.pop_front();
      checks++;
      if (rsp_id !== 2'(e.id) || rsp_data !== 5'(e.data) || c + 1 !== 20) begin
        errors++; $display("FAIL rr_rsp%0d: got id %0d data %0d lat %0d expected id %0d data %0d lat 20",
                           i, rsp_id, rsp_data, c + 1, e.id, e.data);
      end
    end
    req_valid = 4'h0;
    tick();
  endtask

  task automatic test_midrun_reset();
    int g, c, seen;
    exp_t e;
    mode = 1; req_valid = 4'b0010;
    wait_grant(g, c);
    checks++;
    if (g !== 1) begin errors++; $display("FAIL mr_grant: got %0d expected 1", g); end
    tick(); req_valid = 4'h0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rng_en, sqrt_clr_n, sqrt_in, rsp_data, rsp_id} !== 11'd0) begin
      errors++; $display("FAIL mr_async: got %h expected 0", {rsp_valid, rng_en, sqrt_clr_n, sqrt_in, rsp_data, rsp_id});
    end
    tick(); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick(); #1;
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mr_no_rsp: got %0d valid cycles expected 0", seen); end
    req_valid = 4'b0100;
    wait_grant(g, c);
    exp_q.push_back('{2, 16});
    tick(); req_valid = 4'h0;
    checks++;
    if (sqrt_clr_n !== 1'b0) begin errors++; $display("FAIL mr_clear: got %b expected 0", sqrt_clr_n); end
    wait_rsp(c);
    e = exp_q.pop_front();
    checks++;
    if (rsp_id !== 2'(e.id) || rsp_data !== 5'(e.data) || c + 1 !== 20) begin
      errors++; $display("FAIL mr_rsp: got id %0d data %0d lat %0d expected id %0d data %0d lat 20",
                         rsp_id, rsp_data, c + 1, e.id, e.data);
    end
    tick();
  endtask

  task automatic test_real_kernel();
    int c;
    req_data8 = 32'h0000_4000; req_valid8 = 4'b0010;
    c = 0;
    #1;
    while (req_ready8 == 4'd0 && c < 100) begin @(negedge clk); #1; c++; end
    checks++;
    if (req_ready8 !== 4'b0010) begin errors++; $display("FAIL rk_grant: got %b expected 0010", req_ready8); end
    tick(); req_valid8 = 4'h0;
    c = 1;
    #1;
    while (!rsp_valid8 && c < 600) begin @(negedge clk); #1; c++; end
    checks++;
    if (c !== 262) begin errors++; $display("FAIL rk_latency: got %0d expected 262", c); end
    checks++;
    if (rsp_id8 !== 2'd1) begin errors++; $display("FAIL rk_id: got %0d expected 1", rsp_id8); end
    checks++;
    if (!rsp_valid8 || rsp_data8 < 9'd116 || rsp_data8 > 9'd140) begin
      errors++; $display("FAIL rk_sqrt: got %0d expected 116..140", rsp_data8);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_backpressure();
    test_round_robin();
    test_midrun_reset();
    test_real_kernel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
